// File: rtl/bus_pkg.sv
// Shared definitions for the 6502 bus controller: widths, FSM encoding and
// helpers for the packed region tables (base/mask/wait).
package bus_pkg;
    localparam int AW     = 16;
    localparam int DW     = 8;
    localparam int MAXSLV = 16;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } state_e;

    // Region tables are handled at their maximum size so one helper serves any NSLV.
    function automatic logic [AW-1:0] tbl_addr(input logic [MAXSLV*AW-1:0] tbl, input int i);
        return tbl[i*AW +: AW];
    endfunction

    function automatic logic [3:0] tbl_wait(input logic [MAXSLV*4-1:0] tbl, input int i);
        return tbl[i*4 +: 4];
    endfunction

    function automatic logic [MAXSLV*AW-1:0] tbl_addr_set(input logic [MAXSLV*AW-1:0] tbl,
                                                          input int i, input logic [AW-1:0] v);
        logic [MAXSLV*AW-1:0] t;
        t = tbl;
        t[i*AW +: AW] = v;
        return t;
    endfunction
endpackage

// File: rtl/addr_decode.sv
// Priority address decoder: lowest-index matching region wins, so the
// select vector is one-hot or all zero.
module addr_decode
    import bus_pkg::*;
#(
    parameter int                   NSLV     = 8,
    parameter logic [NSLV*AW-1:0]   SLV_BASE = '0,
    parameter logic [NSLV*AW-1:0]   SLV_MASK = '0
) (
    input  logic [AW-1:0]   addr_i,
    output logic [NSLV-1:0] sel_o
);
    localparam logic [MAXSLV*AW-1:0] BASE_T = (MAXSLV*AW)'(SLV_BASE);
    localparam logic [MAXSLV*AW-1:0] MASK_T = (MAXSLV*AW)'(SLV_MASK);

    logic hit;

    always_comb begin
        sel_o = '0;
        hit   = 1'b0;
        for (int i = 0; i < NSLV; i++) begin
            if (!hit && ((addr_i & tbl_addr(MASK_T, i)) ==
                         (tbl_addr(BASE_T, i) & tbl_addr(MASK_T, i)))) begin
                sel_o[i] = 1'b1;
                hit      = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mem_bus_ctrl.sv
// CPU bus controller: clock-enable generation, region decode, per-region
// wait states, read-data steering and an unmapped-access counter.
module mem_bus_ctrl
    import bus_pkg::*;
#(
    parameter int                  NSLV     = 8,
    parameter int                  CLK_DIV  = 2,
    parameter logic [NSLV*16-1:0]  SLV_BASE = {16'hF000, 16'hD000, 16'hC000, 16'hB000,
                                               16'hA000, 16'h9000, 16'h8000, 16'h0000},
    parameter logic [NSLV*16-1:0]  SLV_MASK = {16'hF000, 16'hF000, 16'hF000, 16'hF000,
                                               16'hF000, 16'hF000, 16'hF000, 16'h8000},
    parameter logic [NSLV*4-1:0]   SLV_WAIT = '0
) (
    input  logic                 clk25,
    input  logic                 rst,
    output logic                 cpu_ce,
    input  logic [AW-1:0]        cpu_addr,
    input  logic                 cpu_we,
    input  logic [DW-1:0]        cpu_dbw,
    output logic [DW-1:0]        cpu_dbr,
    output logic [NSLV-1:0]      slv_sel,
    output logic [NSLV-1:0]      slv_we,
    input  logic [NSLV*DW-1:0]   slv_dbr,
    input  logic                 err_clr,
    output logic [7:0]           err_count
);
    localparam int                   PW     = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [PW-1:0]        LAST   = PW'(CLK_DIV - 1);
    localparam logic [MAXSLV*4-1:0]  WAIT_T = (MAXSLV*4)'(SLV_WAIT);

    state_e          state_q;
    logic [PW-1:0]   phase_q;
    logic [7:0]      wcnt_q;
    logic            waited_q;
    logic            cpu_ce_q;
    logic [NSLV-1:0] sel_q;
    logic [7:0]      err_q, err_d;
    logic [3:0]      sel_wait;
    logic [7:0]      wload;
    logic            unused_dbw;

    // Write data goes straight from the CPU to the slaves outside this block.
    assign unused_dbw = ^cpu_dbw;

    addr_decode #(
        .NSLV     (NSLV),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_dec (
        .addr_i (cpu_addr),
        .sel_o  (slv_sel)
    );

    always_comb begin
        sel_wait = '0;
        for (int i = 0; i < NSLV; i++)
            if (slv_sel[i]) sel_wait = sel_wait | tbl_wait(WAIT_T, i);
        wload = 8'(32'(sel_wait) * CLK_DIV - 1);
    end

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            state_q  <= RUN;
            phase_q  <= '0;
            wcnt_q   <= '0;
            waited_q <= 1'b0;
            cpu_ce_q <= 1'b0;
        end else begin
            cpu_ce_q <= 1'b0;
            if (cpu_ce_q) waited_q <= 1'b0;
            case (state_q)
                RUN: begin
                    if (phase_q == LAST) begin
                        phase_q <= '0;
                        if (sel_wait != 4'd0 && !waited_q) begin
                            state_q  <= WAIT;
                            wcnt_q   <= wload;
                            waited_q <= 1'b1;
                        end else begin
                            cpu_ce_q <= 1'b1;
                        end
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                WAIT: begin
                    if (wcnt_q == 8'd0) begin
                        cpu_ce_q <= 1'b1;
                        phase_q  <= '0;
                        state_q  <= RUN;
                    end else begin
                        wcnt_q <= wcnt_q - 8'd1;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    always_comb begin
        err_d = err_q;
        if (err_clr)
            err_d = 8'd0;
        else if (cpu_ce_q && slv_sel == '0 && err_q != 8'hFF)
            err_d = err_q + 8'd1;
    end

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            sel_q <= '0;
            err_q <= '0;
        end else begin
            if (cpu_ce_q) sel_q <= slv_sel;
            err_q <= err_d;
        end
    end

    // Unselected slaves contribute all-ones so the AND leaves the selected byte.
    always_comb begin
        cpu_dbr = '1;
        for (int i = 0; i < NSLV; i++)
            if (sel_q[i]) cpu_dbr = cpu_dbr & slv_dbr[i*DW +: DW];
    end

    assign cpu_ce    = cpu_ce_q;
    assign slv_we    = {NSLV{cpu_ce_q & cpu_we}} & slv_sel;
    assign err_count = err_q;
endmodule

// File: doc/mem_bus_ctrl.md
# mem_bus_ctrl

Parametrised CPU bus controller for the 6502 system. It replaces the fixed clock toggle, hard-wired address decode, registered chip-selects and AND-combined read mux with one block. The block generates a CPU clock-enable from clk25 and decodes up to NSLV address regions from parameter tables. It also inserts per-region wait states, which are new behaviour, and counts accesses to unmapped addresses. It sits between the cpu instance and all memory/peripheral slaves.

## Interface
- NSLV, 8, number of slave regions (1-16)
- CLK_DIV, 2, clk25 cycles per CPU cycle (2-16)
- SLV_BASE, NSLV×16 bits packed, region i base address in bits [16i+15:16i]
- SLV_MASK, NSLV×16 bits packed, region i compare mask; 1 = bit compared
- SLV_WAIT, NSLV×4 bits packed, extra CPU cycles inserted for region i (0-15)

- clk25  in  1  main clock
- rst  in  1  reset; asynchronous, active-high
- cpu_ce  out  1  one-clk25-cycle CPU clock-enable pulse
- cpu_addr  in  16  CPU address, stable between cpu_ce pulses
- cpu_we  in  1  CPU write request
- cpu_dbw  in  8  CPU write data; passed unchanged to slaves
- cpu_dbr  out  8  read data to CPU
- slv_sel  out  NSLV  one-hot combinational decode of cpu_addr
- slv_we  out  NSLV  write strobe, one clk25 cycle
- slv_dbr  in  NSLV×8  slave read data, packed
- err_clr  in  1  synchronous clear of err_count
- err_count  out  8  saturating count of unmapped accesses

## Operation
- Decode: region i matches when (cpu_addr & SLV_MASK[i]) == (SLV_BASE[i] & SLV_MASK[i]). When more than one region matches, the lowest index wins, so slv_sel is strictly one-hot or zero. Unmapped means no region matches.
- Phase counter counts 0..CLK_DIV-1 and wraps.
- FSM states: RUN and WAIT.
  - RUN, phase == CLK_DIV-1, selected region's SLV_WAIT = 0 or already waited this CPU cycle: pulse cpu_ce.
  - RUN, phase == CLK_DIV-1, SLV_WAIT = w > 0 and not yet waited: go to WAIT. Load wcnt = w×CLK_DIV−1. No cpu_ce pulse.
  - WAIT: decrement wcnt every clk25 cycle. At wcnt == 0, pulse cpu_ce, set the phase counter to 0, and return to RUN.
  - The "waited" flag clears on every cpu_ce.
- Write strobe: slv_we[i] = cpu_ce & cpu_we & slv_sel[i]. There is never a strobe in WAIT except on the terminating cpu_ce cycle.
- Read steering: sel_q <= slv_sel on cpu_ce. cpu_dbr = bitwise AND over i of (sel_q[i] ? slv_dbr[i] : 8'hFF). When sel_q is all zero, cpu_dbr = 8'hFF.
- Slave read convention: a slave samples the address on (cpu_ce & slv_sel[i]). Its data must be valid from the following clk25 cycle until the next cpu_ce.
- Error counter: on a cpu_ce with no region matched, err_count increments and saturates at 255. err_clr takes priority over an increment in the same cycle.

## Timing
- Reset values:
  - cpu_ce 0, cpu_dbr 8'hFF, slv_we 0, err_count 0
  - phase 0, FSM in RUN, sel_q 0, waited flag 0
  - slv_sel is combinational and is not reset.
- After rst deasserts, the first cpu_ce occurs at the CLK_DIV-th rising edge of clk25.
- A zero-wait CPU cycle lasts exactly CLK_DIV clk25 cycles. A region with SLV_WAIT = w lasts (w+1)×CLK_DIV clk25 cycles.
- cpu_dbr reflects the new sel_q one clk25 cycle after cpu_ce.
- rst asserted during WAIT aborts immediately: no cpu_ce pulse and no slv_we strobe is produced.

## Structure
- Shared package bus_pkg holds:
  - region-table pack/unpack helper functions
  - FSM state encoding (RUN=0, WAIT=1)
  - widths AW=16 and DW=8
- Sub-module addr_decode: purely combinational priority match, parametrised by NSLV, SLV_BASE and SLV_MASK. Output is the one-hot slv_sel.
- mem_bus_ctrl holds the phase counter, FSM, wait counter, sel_q, read mux and error counter.

## Test plan
- CLK_DIV=2, all SLV_WAIT=0, reads to $FF10 (ROM region, slave returns $A5) -> cpu_ce every 2 cycles; cpu_dbr=$A5 one cycle after the next cpu_ce.
- Overlapping regions 0 ($0000/mask $8000) and 1 ($0000/mask $0000), address $1234 -> slv_sel=0b01. Address $9234 -> slv_sel=0b10.
- Region 3 with SLV_WAIT=2, CLK_DIV=4, write $5A -> 12 clk25 cycles between cpu_ce pulses; slv_we[3] high for exactly 1 cycle, on the second cpu_ce.
- Unmapped address, 300 consecutive cycles -> cpu_dbr=$FF and err_count saturates at 255. err_clr asserted together with an increment -> err_count=0.
- rst pulsed while in WAIT -> cpu_ce=0, slv_we=0 and err_count=0 immediately. First cpu_ce follows CLK_DIV cycles after rst release.
